// File: rtl/vector_iterative_divide_stage.sv
// rtl/vector_iterative_divide_stage.sv - multi-cycle per-lane integer divide/remainder unit
module vector_iterative_divide_stage #(
    parameter int LANES            = 16,
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_IDX_WIDTH = 2,
    parameter int CNT_WIDTH        = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          of_instruction_valid,
    input  logic [1:0]                    of_op,
    input  logic [LANES*DATA_WIDTH-1:0]   of_operand1,
    input  logic [LANES*DATA_WIDTH-1:0]   of_operand2,
    input  logic [LANES-1:0]              of_mask_value,
    input  logic [THREAD_IDX_WIDTH-1:0]   of_thread_idx,
    input  logic                          wb_rollback_en,
    input  logic [THREAD_IDX_WIDTH-1:0]   wb_rollback_thread_idx,
    output logic                          dv_busy,
    output logic                          dv_instruction_valid,
    output logic [LANES*DATA_WIDTH-1:0]   dv_result,
    output logic [LANES-1:0]              dv_mask_value,
    output logic [THREAD_IDX_WIDTH-1:0]   dv_thread_idx,
    output logic [LANES-1:0]              dv_div_by_zero
);

    localparam int W = DATA_WIDTH;

    // op[1] selects remainder, op[0] selects unsigned
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_NORMALIZE = 3'd1,
        S_ITERATE   = 3'd2,
        S_FIXUP     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic [1:0]                      op_q, op_d;
    logic [THREAD_IDX_WIDTH-1:0]     thread_q, thread_d;
    logic [LANES-1:0]                mask_q, mask_d;
    logic [LANES-1:0][W-1:0]         dvd_q, dvd_d;
    logic [LANES-1:0][W-1:0]         dvs_q, dvs_d;
    logic [LANES-1:0][W-1:0]         rem_q, rem_d;
    logic [LANES-1:0][W-1:0]         quo_q, quo_d;
    logic [LANES-1:0]                qneg_q, qneg_d;
    logic [LANES-1:0]                rneg_q, rneg_d;
    logic [LANES-1:0]                zero_q, zero_d;
    logic [LANES-1:0][W-1:0]         res_q, res_d;
    logic [LANES-1:0]                out_mask_q, out_mask_d;
    logic [THREAD_IDX_WIDTH-1:0]     out_thread_q, out_thread_d;
    logic [LANES-1:0]                dbz_q, dbz_d;

    logic                            busy;
    logic                            accept;
    logic                            kill;

    logic [W:0]                      shifted;
    logic [W:0]                      diff;
    logic                            qbit;
    logic                            s1;
    logic                            s2;
    logic [W-1:0]                    q_fix;
    logic [W-1:0]                    r_fix;

    assign busy   = (state_q == S_NORMALIZE) || (state_q == S_ITERATE) || (state_q == S_FIXUP);
    assign accept = of_instruction_valid && !busy &&
                    !(wb_rollback_en && (wb_rollback_thread_idx == of_thread_idx));
    // Rollback only cancels work still in flight; a presented result is never retracted
    assign kill   = busy && wb_rollback_en && (wb_rollback_thread_idx == thread_q);

    // State register and all datapath flops, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            thread_q     <= '0;
            mask_q       <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            qneg_q       <= '0;
            rneg_q       <= '0;
            zero_q       <= '0;
            res_q        <= '0;
            out_mask_q   <= '0;
            out_thread_q <= '0;
            dbz_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            thread_q     <= thread_d;
            mask_q       <= mask_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            zero_q       <= zero_d;
            res_q        <= res_d;
            out_mask_q   <= out_mask_d;
            out_thread_q <= out_thread_d;
            dbz_q        <= dbz_d;
        end
    end

    // Next-state logic: issue, iteration count, rollback cancellation
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_NORMALIZE;
            S_NORMALIZE: state_d = kill ? S_IDLE : S_ITERATE;
            S_ITERATE: begin
                if (kill)                state_d = S_IDLE;
                else if (cnt_q == '0)    state_d = S_FIXUP;
                else                     state_d = S_ITERATE;
            end
            S_FIXUP:     state_d = kill ? S_IDLE : S_DONE;
            S_DONE:      state_d = accept ? S_NORMALIZE : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath: latch on accept, sign-strip, restoring iterations, sign fixup
    always_comb begin
        cnt_d        = cnt_q;
        op_d         = op_q;
        thread_d     = thread_q;
        mask_d       = mask_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        zero_d       = zero_q;
        res_d        = res_q;
        out_mask_d   = out_mask_q;
        out_thread_d = out_thread_q;
        dbz_d        = dbz_q;
        shifted      = '0;
        diff         = '0;
        qbit         = 1'b0;
        s1           = 1'b0;
        s2           = 1'b0;
        q_fix        = '0;
        r_fix        = '0;

        if (accept) begin
            op_d     = of_op;
            thread_d = of_thread_idx;
            mask_d   = of_mask_value;
            dvd_d    = of_operand1;
            dvs_d    = of_operand2;
        end else begin
            case (state_q)
                S_NORMALIZE: begin
                    for (int l = 0; l < LANES; l++) begin
                        s1        = !op_q[0] && dvd_q[l][W-1];
                        s2        = !op_q[0] && dvs_q[l][W-1];
                        dvd_d[l]  = s1 ? (~dvd_q[l] + 1'b1) : dvd_q[l];
                        dvs_d[l]  = s2 ? (~dvs_q[l] + 1'b1) : dvs_q[l];
                        qneg_d[l] = s1 ^ s2;
                        rneg_d[l] = s1;
                        zero_d[l] = (dvs_q[l] == '0);
                    end
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = CNT_WIDTH'(W - 1);
                end
                S_ITERATE: begin
                    for (int l = 0; l < LANES; l++) begin
                        shifted  = {rem_q[l], dvd_q[l][cnt_q]};
                        diff     = shifted - {1'b0, dvs_q[l]};
                        qbit     = !diff[W];
                        rem_d[l] = qbit ? diff[W-1:0] : shifted[W-1:0];
                        quo_d[l] = {quo_q[l][W-2:0], qbit};
                    end
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                end
                S_FIXUP: begin
                    // A zero divisor leaves the dividend magnitude in the remainder,
                    // so re-applying the dividend sign restores the original dividend.
                    if (!kill) begin
                        for (int l = 0; l < LANES; l++) begin
                            q_fix = qneg_q[l] ? (~quo_q[l] + 1'b1) : quo_q[l];
                            r_fix = rneg_q[l] ? (~rem_q[l] + 1'b1) : rem_q[l];
                            if (zero_q[l]) q_fix = '1;
                            res_d[l] = !mask_q[l] ? '0 : (op_q[1] ? r_fix : q_fix);
                            dbz_d[l] = mask_q[l] && zero_q[l];
                        end
                        out_mask_d   = mask_q;
                        out_thread_d = thread_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dv_busy              = busy;
    assign dv_instruction_valid = (state_q == S_DONE);
    assign dv_result            = res_q;
    assign dv_mask_value        = out_mask_q;
    assign dv_thread_idx        = out_thread_q;
    assign dv_div_by_zero       = dbz_q;

endmodule

// File: tb/tb_vector_iterative_divide_stage.sv
// tb/tb_vector_iterative_divide_stage.sv - randomized and directed bench for the divide stage
module tb_vector_iterative_divide_stage;

    localparam int L  = 16;
    localparam int W  = 32;
    localparam int TW = 2;
    localparam int LAT = W + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             of_instruction_valid;
    logic [1:0]       of_op;
    logic [L*W-1:0]   of_operand1;
    logic [L*W-1:0]   of_operand2;
    logic [L-1:0]     of_mask_value;
    logic [TW-1:0]    of_thread_idx;
    logic             wb_rollback_en;
    logic [TW-1:0]    wb_rollback_thread_idx;
    logic             dv_busy;
    logic             dv_instruction_valid;
    logic [L*W-1:0]   dv_result;
    logic [L-1:0]     dv_mask_value;
    logic [TW-1:0]    dv_thread_idx;
    logic [L-1:0]     dv_div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    logic [L*W-1:0]   exp_res;
    logic [L-1:0]     exp_dbz;
    logic [L-1:0]     exp_mask;
    logic [TW-1:0]    exp_thread;
    logic [L*W-1:0]   held_res;
    logic [L*W-1:0]   va, vb;
    int               n;
    int               saw;

    vector_iterative_divide_stage #(
        .LANES(L), .DATA_WIDTH(W), .THREAD_IDX_WIDTH(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .of_instruction_valid(of_instruction_valid),
        .of_op(of_op),
        .of_operand1(of_operand1),
        .of_operand2(of_operand2),
        .of_mask_value(of_mask_value),
        .of_thread_idx(of_thread_idx),
        .wb_rollback_en(wb_rollback_en),
        .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .dv_busy(dv_busy),
        .dv_instruction_valid(dv_instruction_valid),
        .dv_result(dv_result),
        .dv_mask_value(dv_mask_value),
        .dv_thread_idx(dv_thread_idx),
        .dv_div_by_zero(dv_div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lane_ref(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int sa;
        int sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        sa = int'(a);
        sb = int'(b);
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic predict(input logic [1:0] op, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                           input logic [L-1:0] mask, input logic [TW-1:0] thr);
        exp_res = '0;
        exp_dbz = '0;
        for (int l = 0; l < L; l++) begin
            if (mask[l]) begin
                exp_res[l*W +: W] = lane_ref(op, a[l*W +: W], b[l*W +: W]);
                exp_dbz[l]        = (b[l*W +: W] == 0);
            end
        end
        exp_mask   = mask;
        exp_thread = thr;
    endtask

    task automatic check(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_issue(input logic [1:0] op, input logic [L*W-1:0] a,
                               input logic [L*W-1:0] b, input logic [L-1:0] mask,
                               input logic [TW-1:0] thr);
        of_op                = op;
        of_operand1          = a;
        of_operand2          = b;
        of_mask_value        = mask;
        of_thread_idx        = thr;
        of_instruction_valid = 1'b1;
    endtask

    // Counts negedges from `start` until valid is seen, bounded
    task automatic wait_valid(input int start, output int cnt);
        cnt = start;
        while (!dv_instruction_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, dv_result, exp_res);
        check({tag, ".dbz"}, dv_div_by_zero, exp_dbz);
        check({tag, ".mask"}, dv_mask_value, exp_mask);
        check({tag, ".thread"}, dv_thread_idx, exp_thread);
    endtask

    // Called just after a negedge with the unit idle; returns at the negedge after valid drops
    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [L*W-1:0] a,
                                 input logic [L*W-1:0] b, input logic [L-1:0] mask,
                                 input logic [TW-1:0] thr);
        int cnt;
        predict(op, a, b, mask, thr);
        drive_issue(op, a, b, mask, thr);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        check({tag, ".busy"}, dv_busy, 1);
        wait_valid(0, cnt);
        check({tag, ".latency"}, cnt, LAT);
        check_outputs(tag);
        @(negedge clk);
        check({tag, ".pulse"}, dv_instruction_valid, 0);
    endtask

    task automatic rand_operands(output logic [L*W-1:0] a, output logic [L*W-1:0] b);
        for (int l = 0; l < L; l++) begin
            a[l*W +: W] = $urandom;
            case ($urandom_range(0, 7))
                0: b[l*W +: W] = 0;
                1: begin a[l*W +: W] = 32'h8000_0000; b[l*W +: W] = 32'hFFFF_FFFF; end
                2: b[l*W +: W] = $urandom_range(1, 15);
                3: b[l*W +: W] = -$urandom_range(1, 15);
                default: b[l*W +: W] = $urandom >> $urandom_range(0, 31);
            endcase
        end
    endtask

    initial begin
        reset                  = 1'b1;
        of_instruction_valid   = 1'b0;
        of_op                  = '0;
        of_operand1            = '0;
        of_operand2            = '0;
        of_mask_value          = '0;
        of_thread_idx          = '0;
        wb_rollback_en         = 1'b0;
        wb_rollback_thread_idx = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", dv_busy, 0);
        check("rst.valid", dv_instruction_valid, 0);
        check("rst.result", dv_result, 0);
        check("rst.dbz", dv_div_by_zero, 0);
        check("rst.mask", dv_mask_value, 0);
        check("rst.thread", dv_thread_idx, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases in lane 0
        va = '0; vb = '0;
        va[0 +: W] = 100; vb[0 +: W] = 7;
        run_and_check("divu100_7", 2'b01, va, vb, 16'h0001, 2'd0);
        check("divu100_7.lane0", dv_result[0 +: W], 14);
        run_and_check("remu100_7", 2'b11, va, vb, 16'h0001, 2'd1);
        check("remu100_7.lane0", dv_result[0 +: W], 2);
        va[0 +: W] = -100;
        run_and_check("divs", 2'b00, va, vb, 16'h0001, 2'd2);
        check("divs.lane0", dv_result[0 +: W], 32'hFFFF_FFF2);
        run_and_check("rems", 2'b10, va, vb, 16'h0001, 2'd3);
        check("rems.lane0", dv_result[0 +: W], 32'hFFFF_FFFE);
        va[0 +: W] = 32'h8000_0000; vb[0 +: W] = 32'hFFFF_FFFF;
        run_and_check("divs_ovf", 2'b00, va, vb, 16'h0001, 2'd0);
        check("divs_ovf.lane0", dv_result[0 +: W], 32'h8000_0000);
        run_and_check("rems_ovf", 2'b10, va, vb, 16'h0001, 2'd0);
        check("rems_ovf.lane0", dv_result[0 +: W], 0);

        // Divide by zero in lane 3, other lanes ordinary
        for (int l = 0; l < L; l++) begin
            va[l*W +: W] = 1000 + l;
            vb[l*W +: W] = l + 1;
        end
        va[3*W +: W] = 55; vb[3*W +: W] = 0;
        run_and_check("dbz_divu", 2'b01, va, vb, 16'hFFFF, 2'd1);
        check("dbz_divu.lane3", dv_result[3*W +: W], 32'hFFFF_FFFF);
        check("dbz_divu.flags", dv_div_by_zero, 16'h0008);
        run_and_check("dbz_remu", 2'b11, va, vb, 16'hFFFF, 2'd1);
        check("dbz_remu.lane3", dv_result[3*W +: W], 55);
        run_and_check("dbz_masked", 2'b01, va, vb, 16'hFFF7, 2'd1);
        check("dbz_masked.lane3", dv_result[3*W +: W], 0);
        check("dbz_masked.flags", dv_div_by_zero, 0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            rand_operands(va, vb);
            run_and_check("rand", 2'($urandom), va, vb, L'($urandom), TW'($urandom));
        end

        // Issue blocked by a same-thread rollback in the same cycle
        drive_issue(2'b01, va, vb, 16'hFFFF, 2'd1);
        wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd1;
        @(negedge clk);
        of_instruction_valid = 1'b0; wb_rollback_en = 1'b0;
        check("issue_rb.busy", dv_busy, 0);

        // Rollback of the in-flight thread during ITERATE cycle 10
        held_res = exp_res;
        rand_operands(va, vb);
        drive_issue(2'b00, va, vb, 16'hFFFF, 2'd1);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        repeat (10) @(negedge clk);
        wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd1;
        @(negedge clk);
        wb_rollback_en = 1'b0;
        check("rb_same.busy", dv_busy, 0);
        saw = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (dv_instruction_valid) saw = 1;
        end
        check("rb_same.novalid", saw, 0);
        check("rb_same.hold", dv_result, held_res);

        // Rollback of another thread leaves the operation intact
        rand_operands(va, vb);
        predict(2'b10, va, vb, 16'hA5A5, 2'd1);
        drive_issue(2'b10, va, vb, 16'hA5A5, 2'd1);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        repeat (10) @(negedge clk);
        wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd2;
        @(negedge clk);
        wb_rollback_en = 1'b0;
        wait_valid(11, n);
        check("rb_other.latency", n, LAT);
        check_outputs("rb_other");
        @(negedge clk);

        // Issue while busy is ignored
        rand_operands(va, vb);
        predict(2'b01, va, vb, 16'hFFFF, 2'd2);
        drive_issue(2'b01, va, vb, 16'hFFFF, 2'd2);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        repeat (2) @(negedge clk);
        drive_issue(2'b10, ~va, vb + 1, 16'h0F0F, 2'd3);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        wait_valid(3, n);
        check("busy_issue.latency", n, LAT);
        check_outputs("busy_issue");
        @(negedge clk);
        check("busy_issue.idle", dv_instruction_valid, 0);

        // Back-to-back: second issue in the DONE cycle
        rand_operands(va, vb);
        predict(2'b00, va, vb, 16'hFFFF, 2'd0);
        drive_issue(2'b00, va, vb, 16'hFFFF, 2'd0);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        wait_valid(0, n);
        check("b2b_first.latency", n, LAT);
        check_outputs("b2b_first");
        rand_operands(va, vb);
        predict(2'b11, va, vb, 16'h3C3C, 2'd3);
        drive_issue(2'b11, va, vb, 16'h3C3C, 2'd3);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        check("b2b.pulse", dv_instruction_valid, 0);
        check("b2b.busy", dv_busy, 1);
        wait_valid(1, n);
        check("b2b_second.spacing", n, W + 3);
        check_outputs("b2b_second");
        @(negedge clk);

        // Reset mid-ITERATE clears outputs at once and discards the work
        rand_operands(va, vb);
        drive_issue(2'b01, va, vb, 16'hFFFF, 2'd3);
        @(negedge clk);
        of_instruction_valid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst.busy", dv_busy, 0);
        check("mid_rst.valid", dv_instruction_valid, 0);
        check("mid_rst.result", dv_result, 0);
        check("mid_rst.dbz", dv_div_by_zero, 0);
        check("mid_rst.mask", dv_mask_value, 0);
        check("mid_rst.thread", dv_thread_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        saw = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (dv_instruction_valid) saw = 1;
        end
        check("mid_rst.novalid", saw, 0);
        rand_operands(va, vb);
        run_and_check("post_rst", 2'b10, va, vb, 16'hFFFF, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
